// File: rtl/adau_spi_master_if.sv
// Command handshake and codec SPI pins of the ADAU SPI master.
// The master modport is the serialiser side; the slave modport is the sequencer/codec side.
interface adau_spi_master_if;
  logic [31:0] command;
  logic        command_valid;
  logic        spi_ready;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [7:0]  rdata;
  logic        rdata_valid;

  modport master (
    input  command, command_valid, spi_miso,
    output spi_ready, spi_cs_n, spi_sclk, spi_mosi, rdata, rdata_valid
  );

  modport slave (
    output command, command_valid, spi_miso,
    input  spi_ready, spi_cs_n, spi_sclk, spi_mosi, rdata, rdata_valid
  );
endinterface

// File: rtl/adau_spi_master.sv
// Serialises 32-bit ADAU register commands as mode-0 SPI frames (CLATCH/CCLK/CDATA/COUT).
// Optional read-back capture of the last COUT byte is enabled by defining ADAU_SPI_READBACK_EN.
module adau_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic clk,
  input  logic reset,
  adau_spi_master_if.master io_spi
);

  // state | meaning
  // IDLE  | spi_ready high, waiting for command_valid
  // SETUP | cs_n low, sclk low for CLK_DIV cycles
  // SHIFT | 32 bits, CLK_DIV high then CLK_DIV low per bit
  // HOLD  | cs_n low, sclk low for CLK_DIV cycles after the last bit
  // GAP   | cs_n high for CS_GAP cycles
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LD = 8'(CS_GAP - 1);

  state_t      r_state;
  logic [7:0]  r_phase;
  logic [5:0]  r_bit;
  logic [30:0] r_shift;
  logic        r_ready;
  logic        r_cs_n;
  logic        r_sclk;
  logic        r_mosi;

  logic        w_phase_done;
  logic        w_accept;

  assign w_phase_done = (r_phase == 8'd0);
  assign w_accept     = (r_state == S_IDLE) && r_ready && io_spi.command_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= 8'd0;
      r_bit   <= 6'd0;
      r_shift <= 31'd0;
      r_ready <= 1'b0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= io_spi.command[30:0];
            r_mosi  <= io_spi.command[31];
            r_cs_n  <= 1'b0;
            r_ready <= 1'b0;
            r_phase <= DIV_LD;
            r_bit   <= 6'd0;
            r_state <= S_SETUP;
          end else begin
            r_ready <= 1'b1;
          end
        end

        S_SETUP: begin
          if (w_phase_done) begin
            r_sclk  <= 1'b1;
            r_bit   <= r_bit + 6'd1;
            r_phase <= DIV_LD;
            r_state <= S_SHIFT;
          end else begin
            r_phase <= r_phase - 8'd1;
          end
        end

        // r_bit counts rising edges already issued; the 32nd low phase runs out without a 33rd edge
        S_SHIFT: begin
          if (!w_phase_done) begin
            r_phase <= r_phase - 8'd1;
          end else begin
            r_phase <= DIV_LD;
            if (r_sclk) begin
              r_sclk <= 1'b0;
              if (r_bit != 6'd32) begin
                r_mosi  <= r_shift[30];
                r_shift <= {r_shift[29:0], 1'b0};
              end
            end else if (r_bit == 6'd32) begin
              r_state <= S_HOLD;
            end else begin
              r_sclk <= 1'b1;
              r_bit  <= r_bit + 6'd1;
            end
          end
        end

        S_HOLD: begin
          if (w_phase_done) begin
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_phase <= GAP_LD;
            r_state <= S_GAP;
          end else begin
            r_phase <= r_phase - 8'd1;
          end
        end

        S_GAP: begin
          if (w_phase_done) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_phase <= r_phase - 8'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_spi.spi_ready = r_ready;
  assign io_spi.spi_cs_n  = r_cs_n;
  assign io_spi.spi_sclk  = r_sclk;
  assign io_spi.spi_mosi  = r_mosi;

`ifdef ADAU_SPI_READBACK_EN
  logic       r_rw;
  logic [7:0] r_miso_sr;
  logic [7:0] r_rdata;
  logic       r_rdata_valid;
  logic       w_rise;
  logic       w_hold_end;

  // Same edges on which the FSM drives sclk high / releases cs_n.
  assign w_rise = w_phase_done &&
                  ((r_state == S_SETUP) ||
                   ((r_state == S_SHIFT) && !r_sclk && (r_bit != 6'd32)));
  assign w_hold_end = w_phase_done && (r_state == S_HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rw          <= 1'b0;
      r_miso_sr     <= 8'd0;
      r_rdata       <= 8'd0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      if (w_accept) begin
        r_rw <= io_spi.command[24];
      end
      if (w_rise) begin
        r_miso_sr <= {r_miso_sr[6:0], io_spi.spi_miso};
      end
      if (w_hold_end && r_rw) begin
        r_rdata       <= r_miso_sr;
        r_rdata_valid <= 1'b1;
      end
    end
  end

  assign io_spi.rdata       = r_rdata;
  assign io_spi.rdata_valid = r_rdata_valid;
`else
  // Read-back disabled: COUT is ignored and the masking keeps rdata at zero.
  assign io_spi.rdata       = 8'h00 & {8{io_spi.spi_miso}};
  assign io_spi.rdata_valid = 1'b0;
`endif

endmodule
